sub: RTL and testbench

Registered 32-bit two's-complement subtractor with ARM-style condition-flag generation, part of the ALU datapath. Computes In1 − In2 and, when flag-setting is requested, produces an updated NZCV flag nibble; otherwise it passes the incoming flags through unchanged. Result and flags are registered once, on the ALU clock.

---
 rtl/sub_pkg.sv | 29 ++
 rtl/sub_flag_gen.sv | 23 ++
 rtl/sub.sv | 56 +++++
 tb/tb_sub.sv | 122 ++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared ALU definitions: datapath widths, NZCV bit positions and the flag nibble type.
// Imported by the subtractor and reusable by the adder, compare and other ALU units.
package sub_pkg;

    localparam int DATA_W = 32;
    localparam int FLAG_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic nzcv_t pack_nzcv(input logic n, input logic z, input logic c, input logic v);
        nzcv_t f;
        f.n = n;
        f.z = z;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/sub_flag_gen.sv
// Combinational NZCV generation from a 33-bit a + ~b + 1 sum.
// Shared with the compare unit, so it only looks at the operands and the raw sum.
module sub_flag_gen
    import sub_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W:0]   diff33,
    output logic              N,
    output logic              Z,
    output logic              C,
    output logic              V
);

    always_comb begin
        N = diff33[DATA_W-1];
        Z = (diff33[DATA_W-1:0] == '0);
        // Carry out of a + ~b + 1 is the inverted borrow: set when a >= b unsigned.
        C = diff33[DATA_W];
        V = (a[DATA_W-1] != b[DATA_W-1]) && (diff33[DATA_W-1] != a[DATA_W-1]);
    end

endmodule

// File: rtl/sub.sv
// Registered 32-bit subtractor with optional NZCV update; flags pass through when S is low.
// One cycle latency, one operation per cycle, no input-to-output combinational path.
module sub
    import sub_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   In1,
    input  logic [DATA_W-1:0]   In2,
    input  logic [FLAG_W-1:0]   Flag,
    input  logic                S,
    output logic [DATA_W-1:0]   Result,
    output logic [FLAG_W-1:0]   New_Flag
);

    logic [DATA_W:0]   diff33;
    logic              flag_n;
    logic              flag_z;
    logic              flag_c;
    logic              flag_v;
    logic [DATA_W-1:0] result_d;
    logic [DATA_W-1:0] result_q;
    nzcv_t             new_flag_d;
    nzcv_t             new_flag_q;

    assign diff33 = {1'b0, In1} + {1'b0, ~In2} + {{DATA_W{1'b0}}, 1'b1};

    sub_flag_gen u_flag_gen (
        .a      (In1),
        .b      (In2),
        .diff33 (diff33),
        .N      (flag_n),
        .Z      (flag_z),
        .C      (flag_c),
        .V      (flag_v)
    );

    always_comb begin
        result_d   = diff33[DATA_W-1:0];
        new_flag_d = S ? pack_nzcv(flag_n, flag_z, flag_c, flag_v) : nzcv_t'(Flag);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q   <= '0;
            new_flag_q <= '0;
        end else begin
            result_q   <= result_d;
            new_flag_q <= new_flag_d;
        end
    end

    assign Result   = result_q;
    assign New_Flag = new_flag_q;

endmodule

// File: tb/tb_sub.sv
// Directed bench for the registered subtractor: hand-computed results and NZCV flags,
// including reset behaviour and flag passthrough.
module tb_sub;

    logic        clk;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  flag;
    logic        s;
    logic [31:0] result;
    logic [3:0]  new_flag;

    int errors = 0;
    int checks = 0;

    sub dut (
        .clk      (clk),
        .rst      (rst),
        .In1      (in1),
        .In2      (in2),
        .Flag     (flag),
        .S        (s),
        .Result   (result),
        .New_Flag (new_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f, input logic sv);
        @(negedge clk);
        in1  = a;
        in2  = b;
        flag = f;
        s    = sv;
    endtask

    task automatic step_check(input string tag, input logic [31:0] exp_res, input logic [3:0] exp_flag);
        @(posedge clk);
        #1;
        check({tag, ".result"}, result, exp_res);
        check({tag, ".flags"}, {28'd0, new_flag}, {28'd0, exp_flag});
    endtask

    initial begin
        rst  = 1'b1;
        in1  = 32'd0;
        in2  = 32'd0;
        flag = 4'b0000;
        s    = 1'b0;
        #1;
        check("reset.result", result, 32'd0);
        check("reset.flags", {28'd0, new_flag}, 32'd0);

        @(negedge clk);
        rst = 1'b0;

        drive(32'h9FFF_FFFF, 32'h3000_0001, 4'b0000, 1'b1);
        step_check("ovf_nobrw", 32'h6FFF_FFFE, 4'b0011);

        // Reset asserted mid-stream clears outputs without waiting for a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("midrst.result", result, 32'd0);
        check("midrst.flags", {28'd0, new_flag}, 32'd0);
        @(posedge clk);
        #1;
        check("rsthold.result", result, 32'd0);
        check("rsthold.flags", {28'd0, new_flag}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step_check("postrst", 32'h6FFF_FFFE, 4'b0011);

        drive(32'd1, 32'hFFFF_FFFD, 4'b0000, 1'b1);
        step_check("borrow_a", 32'd4, 4'b0000);

        drive(32'd4, 32'hFFFF_FFFC, 4'b0000, 1'b1);
        step_check("borrow_b", 32'd8, 4'b0000);

        drive(32'hFFFF_FFFA, 32'd8, 4'b0000, 1'b1);
        step_check("neg", 32'hFFFF_FFF2, 4'b1010);

        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 1'b1);
        step_check("zero_a", 32'd0, 4'b0110);

        drive(32'd10, 32'd10, 4'b0000, 1'b1);
        step_check("zero_b", 32'd0, 4'b0110);

        drive(32'd5, 32'd0, 4'b0000, 1'b1);
        step_check("sub_zero", 32'd5, 4'b0010);

        drive(32'h8000_0000, 32'd1, 4'b0000, 1'b1);
        step_check("minint_m1", 32'h7FFF_FFFF, 4'b0011);

        drive(32'd0, 32'h8000_0000, 4'b0000, 1'b1);
        step_check("zero_minint", 32'h8000_0000, 4'b1001);

        drive(32'd10, 32'd10, 4'b1001, 1'b0);
        step_check("pass_a", 32'd0, 4'b1001);

        drive(32'd10, 32'd10, 4'b0101, 1'b0);
        step_check("pass_b", 32'd0, 4'b0101);

        // S=0 must not compute flags even when the difference would set them.
        drive(32'hFFFF_FFFA, 32'd8, 4'b0110, 1'b0);
        step_check("pass_c", 32'hFFFF_FFF2, 4'b0110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
